// File: rtl/mc_mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_ERROR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JTGT   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // States that sit on the shared memory port waiting for mem_ready.
  function automatic logic isWaitState(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_mips_ctrl_if.sv
// Controller <-> datapath bundle: decoded IR fields and status in, datapath controls out.
interface mc_mips_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       signext;
  logic       shiftl16;
  logic [2:0] alucontrol;
  logic       regwrite;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [1:0] err;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memread, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           signext, shiftl16, alucontrol, regwrite, regdst, memtoreg, err
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memread, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           signext, shiftl16, alucontrol, regwrite, regdst, memtoreg, err
  );
endinterface

// File: rtl/mc_mips_ctrl_funct_dec.sv
// R-type funct decoder: ALU operation, legality and jr detection.
module mc_funct_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       legal_o,
  output logic       isJr_o
);

  // Unsigned variants share the signed ALU op; anything unlisted is illegal.
  always_comb begin
    alucontrol_o = ALU_ADD;
    legal_o      = 1'b1;
    isJr_o       = 1'b0;
    case (funct_i)
      FN_ADD, FN_ADDU: alucontrol_o = ALU_ADD;
      FN_SUB, FN_SUBU: alucontrol_o = ALU_SUB;
      FN_AND:          alucontrol_o = ALU_AND;
      FN_OR:           alucontrol_o = ALU_OR;
      FN_SLT, FN_SLTU: alucontrol_o = ALU_SLT;
      FN_JR:           isJr_o       = 1'b1;
      default:         legal_o      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_mips_ctrl.sv
// Multicycle MIPS control FSM with memory-ready handshake and wait timeout.
module mc_mips_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
)(
  input  logic          clk,
  input  logic          reset,
  mc_mips_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [1:0]       err_q, err_d;

  logic [2:0] rAlu;
  logic       rLegal;
  logic       rIsJr;
  logic       waiting;
  logic       timedOut;
  logic       immSign;
  logic       immLui;
  logic [2:0] immAlu;

  mc_funct_dec uFunctDec (
    .funct_i      (bus.funct),
    .alucontrol_o (rAlu),
    .legal_o      (rLegal),
    .isJr_o       (rIsJr)
  );

  // I-type flavour: ori zero-extends and ORs, lui shifts, addi/addiu sign-extend and add.
  assign immSign = (bus.op == OP_ADDI) || (bus.op == OP_ADDIU);
  assign immLui  = (bus.op == OP_LUI);
  assign immAlu  = (bus.op == OP_ORI) ? ALU_OR : ALU_ADD;

  // A wait cycle that would bring the stall count up to the limit triggers the bus error.
  always_comb begin
    waiting  = isWaitState(state_q) && !bus.mem_ready;
    timedOut = waiting && (TIMEOUT != 0) && ((32'(waitCnt_q) + 32'd1) >= TIMEOUT);
  end

  // Next state, sticky error and Moore outputs; everything is forced low while in reset.
  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    bus.iord       = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcen       = 1'b0;
    bus.pcsrc      = PCSRC_ALU;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = SRCB_B;
    bus.signext    = 1'b0;
    bus.shiftl16   = 1'b0;
    bus.alucontrol = ALU_ADD;
    bus.regwrite   = 1'b0;
    bus.regdst     = REGDST_RT;
    bus.memtoreg   = WB_ALUOUT;
    bus.err        = err_q;

    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = SRCB_FOUR;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcen    = 1'b1;
          state_d     = S_DECODE;
        end else if (timedOut) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        bus.alusrcb = SRCB_IMMSH;
        bus.signext = 1'b1;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (!rLegal) begin
              state_d = S_ERROR;
              err_d   = ERR_ILLEGAL;
            end else if (rIsJr) begin
              state_d = S_JR;
            end else begin
              state_d = S_RTEXEC;
            end
          end
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_J:   state_d = S_JUMP;
          OP_JAL: state_d = S_JAL;
          default: begin
            state_d = S_ERROR;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        bus.signext = 1'b1;
        state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord    = 1'b1;
        bus.memread = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (timedOut) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = REGDST_RT;
        bus.memtoreg = WB_MDR;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (timedOut) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_RTEXEC: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = SRCB_B;
        bus.alucontrol = rAlu;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = REGDST_RD;
        bus.memtoreg = WB_ALUOUT;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = SRCB_B;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = PCSRC_ALUOUT;
        bus.pcen       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
        state_d        = S_FETCH;
      end
      S_IEXEC: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = SRCB_IMM;
        bus.signext    = immSign;
        bus.shiftl16   = immLui;
        bus.alucontrol = immAlu;
        state_d        = S_IWB;
      end
      S_IWB: begin
        bus.regwrite   = 1'b1;
        bus.regdst     = REGDST_RT;
        bus.memtoreg   = WB_ALUOUT;
        bus.signext    = immSign;
        bus.shiftl16   = immLui;
        bus.alucontrol = immAlu;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        bus.pcen  = 1'b1;
        bus.pcsrc = PCSRC_JTGT;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        bus.pcen     = 1'b1;
        bus.pcsrc    = PCSRC_JTGT;
        bus.regwrite = 1'b1;
        bus.regdst   = REGDST_RA;
        bus.memtoreg = WB_PC;
        state_d      = S_FETCH;
      end
      S_JR: begin
        bus.pcen  = 1'b1;
        bus.pcsrc = PCSRC_REG;
        state_d   = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_FETCH;
    endcase

    if (!reset) begin
      bus.iord       = 1'b0;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.pcen       = 1'b0;
      bus.pcsrc      = 2'b00;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.signext    = 1'b0;
      bus.shiftl16   = 1'b0;
      bus.alucontrol = 3'b000;
      bus.regwrite   = 1'b0;
      bus.regdst     = 2'b00;
      bus.memtoreg   = 2'b00;
      bus.err        = 2'b00;
    end
  end

  // Stall counter: restarts on any state change, saturates so a disabled limit never wraps.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_d != state_q) begin
      waitCnt_d = '0;
    end else if (waiting && (waitCnt_q != '1)) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // State, stall count and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mc_mips_ctrl.sv
// Bench for mc_mips_ctrl: per-instruction cycle plans checked every cycle, plus literal probes.
module tb_mc_mips_ctrl;

  localparam int TMO = 4;

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       signext;
    logic       shiftl16;
    logic [2:0] alucontrol;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] err;
  } ctrl_t;

  typedef enum {K_FWAIT, K_FDONE, K_DEC, K_ADDR, K_RDWAIT, K_RDDONE, K_LDWB,
                K_WRWAIT, K_WRDONE, K_REXEC, K_RWB, K_BR, K_IEXEC, K_IWB,
                K_JUMP, K_JAL, K_JR, K_DEAD} stepKind_t;

  typedef enum {C_LW, C_SW, C_R, C_JR, C_BR, C_IMM, C_J, C_JAL, C_BAD} class_t;

  typedef struct {
    stepKind_t  kind;
    logic       rdy;
    logic [1:0] errv;
  } step_t;

  logic clk = 1'b0;
  logic reset;

  mc_mips_ctrl_if bus ();

  mc_mips_ctrl #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ctrl_t      dutOut;
  logic [9:0] dutKey;
  ctrl_t      expCur;
  bit         checkEn = 1'b0;
  int         checks  = 0;
  int         passes  = 0;
  string      curName = "";
  int         curStep = 0;
  step_t      plan[$];

  assign dutOut = {bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
                   bus.alusrca, bus.alusrcb, bus.signext, bus.shiftl16, bus.alucontrol,
                   bus.regwrite, bus.regdst, bus.memtoreg, bus.err};
  assign dutKey = {bus.pcen, bus.pcsrc, bus.regwrite, bus.regdst, bus.memtoreg, bus.err};

  // Instruction class straight from the ISA table.
  function automatic class_t classify(logic [5:0] o, logic [5:0] f);
    class_t c;
    c = C_BAD;
    case (o)
      6'h23: c = C_LW;
      6'h2b: c = C_SW;
      6'h00: begin
        if (f == 6'h08) c = C_JR;
        else if (f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b}) c = C_R;
      end
      6'h04, 6'h05: c = C_BR;
      6'h08, 6'h09, 6'h0d, 6'h0f: c = C_IMM;
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      default: c = C_BAD;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] aluOf(logic [5:0] f);
    logic [2:0] a;
    case (f)
      6'h22, 6'h23: a = 3'b110;
      6'h24:        a = 3'b000;
      6'h25:        a = 3'b001;
      6'h2a, 6'h2b: a = 3'b111;
      default:      a = 3'b010;
    endcase
    return a;
  endfunction

  // Expected control word for one step of an instruction's cycle plan.
  function automatic ctrl_t expOut(stepKind_t k, logic [5:0] o, logic [5:0] f, logic z, logic [1:0] e);
    ctrl_t c;
    c = '0;
    c.alucontrol = 3'b010;
    c.err = e;
    case (k)
      K_FWAIT:  begin c.memread = 1'b1; c.alusrcb = 2'b01; end
      K_FDONE:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1; end
      K_DEC:    begin c.alusrcb = 2'b11; c.signext = 1'b1; end
      K_ADDR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.signext = 1'b1; end
      K_RDWAIT, K_RDDONE: begin c.iord = 1'b1; c.memread = 1'b1; end
      K_LDWB:   begin c.regwrite = 1'b1; c.memtoreg = 2'b01; end
      K_WRWAIT, K_WRDONE: begin c.iord = 1'b1; c.memwrite = 1'b1; end
      K_REXEC:  begin c.alusrca = 1'b1; c.alucontrol = aluOf(f); end
      K_RWB:    begin c.regwrite = 1'b1; c.regdst = 2'b01; end
      K_BR: begin
        c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
        c.pcen = (o == 6'h04) ? z : !z;
      end
      K_IEXEC, K_IWB: begin
        if (k == K_IEXEC) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
        else c.regwrite = 1'b1;
        if (o == 6'h0d) c.alucontrol = 3'b001;
        else if (o == 6'h0f) c.shiftl16 = 1'b1;
        else c.signext = 1'b1;
      end
      K_JUMP:   begin c.pcen = 1'b1; c.pcsrc = 2'b10; end
      K_JAL:    begin c.pcen = 1'b1; c.pcsrc = 2'b10; c.regwrite = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
      K_JR:     begin c.pcen = 1'b1; c.pcsrc = 2'b11; end
      default:  ;
    endcase
    return c;
  endfunction

  // Cycle plan of one instruction: fetch stalls, fetch, decode, then the class-specific tail.
  task automatic buildPlan(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw, input int nDead);
    plan.delete();
    if (fw >= TMO) begin
      repeat (TMO) plan.push_back('{K_FWAIT, 1'b0, 2'b00});
      repeat (nDead) plan.push_back('{K_DEAD, 1'b0, 2'b10});
      return;
    end
    repeat (fw) plan.push_back('{K_FWAIT, 1'b0, 2'b00});
    plan.push_back('{K_FDONE, 1'b1, 2'b00});
    plan.push_back('{K_DEC, 1'b1, 2'b00});
    case (classify(o, f))
      C_LW: begin
        plan.push_back('{K_ADDR, 1'b1, 2'b00});
        repeat (mw) plan.push_back('{K_RDWAIT, 1'b0, 2'b00});
        plan.push_back('{K_RDDONE, 1'b1, 2'b00});
        plan.push_back('{K_LDWB, 1'b1, 2'b00});
      end
      C_SW: begin
        plan.push_back('{K_ADDR, 1'b1, 2'b00});
        repeat (mw) plan.push_back('{K_WRWAIT, 1'b0, 2'b00});
        plan.push_back('{K_WRDONE, 1'b1, 2'b00});
      end
      C_R:   begin plan.push_back('{K_REXEC, 1'b1, 2'b00}); plan.push_back('{K_RWB, 1'b1, 2'b00}); end
      C_IMM: begin plan.push_back('{K_IEXEC, 1'b1, 2'b00}); plan.push_back('{K_IWB, 1'b1, 2'b00}); end
      C_BR:  plan.push_back('{K_BR, 1'b1, 2'b00});
      C_J:   plan.push_back('{K_JUMP, 1'b1, 2'b00});
      C_JAL: plan.push_back('{K_JAL, 1'b1, 2'b00});
      C_JR:  plan.push_back('{K_JR, 1'b1, 2'b00});
      default: repeat (nDead) plan.push_back('{K_DEAD, 1'b0, 2'b01});
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [21:0] actual, input logic [21:0] want);
    checks = checks + 1;
    if (actual === want) passes = passes + 1;
    else $display("[TB] FAIL %s: got %b want %b", name, actual, want);
  endtask

  // Drive one instruction cycle by cycle from posedge+1; optional literal probe on one step.
  task automatic applyStimulus(input string name, input logic [5:0] o, input logic [5:0] f, input logic z,
                               input int fw, input int mw, input int nDead, input int maxSteps,
                               input int probeIdx, input logic [9:0] probeKey);
    int n;
    buildPlan(o, f, fw, mw, nDead);
    n = (maxSteps >= 0 && maxSteps < plan.size()) ? maxSteps : plan.size();
    curName = name;
    for (int i = 0; i < n; i++) begin
      bus.op        = o;
      bus.funct     = f;
      bus.zero      = z;
      bus.mem_ready = plan[i].rdy;
      expCur        = expOut(plan[i].kind, o, f, z, plan[i].errv);
      curStep       = i;
      checkEn       = 1'b1;
      if (i == probeIdx) begin
        #2;
        checkOutput({name, "Probe"}, 22'(dutKey), 22'(probeKey));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset(input string name);
    checkEn       = 1'b0;
    bus.mem_ready = 1'b1;
    reset         = 1'b0;
    #1;
    checkOutput({name, "ResetOut"}, dutOut, 22'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput({name, "ResetHold"}, dutOut, 22'd0);
    reset = 1'b1;
  endtask

  // Single compare process: DUT against the plan's expected word on every active cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checks = checks + 1;
      if (dutOut === expCur) passes = passes + 1;
      else $display("[TB] FAIL %s step %0d: got %b want %b", curName, curStep, dutOut, expCur);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] rFuncts[8];
    logic [5:0] iOps[4];
    rFuncts = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b};
    iOps    = '{6'h08, 6'h09, 6'h0d, 6'h0f};

    reset         = 1'b0;
    bus.op        = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetIdle", dutOut, 22'd0);
    @(posedge clk);
    #1;
    checkOutput("resetIdleHold", dutOut, 22'd0);
    reset = 1'b1;
    bus.op = 6'h23;
    #1;
    checkOutput("fetchCycle1", dutOut, 22'b0_1_0_1_1_00_0_01_0_0_010_0_00_00_00);

    $display("[TB] lw / sw");
    applyStimulus("lw", 6'h23, 6'h00, 1'b0, 0, 0, 0, -1, 4, 10'b0_00_1_00_01_00);
    applyStimulus("lwWait3", 6'h23, 6'h00, 1'b0, 0, 3, 0, -1, 7, 10'b0_00_1_00_01_00);
    applyStimulus("sw", 6'h2b, 6'h00, 1'b0, 0, 1, 0, -1, -1, 10'd0);

    $display("[TB] R-type and I-type");
    for (int i = 0; i < 8; i++) applyStimulus("rtype", 6'h00, rFuncts[i], 1'b0, 0, 0, 0, -1, -1, 10'd0);
    for (int i = 0; i < 4; i++) applyStimulus("itype", iOps[i], 6'h15, 1'b0, 0, 0, 0, -1, -1, 10'd0);
    applyStimulus("addFetchWait", 6'h00, 6'h20, 1'b0, 2, 0, 0, -1, -1, 10'd0);

    $display("[TB] branches and jumps");
    applyStimulus("beqTaken", 6'h04, 6'h00, 1'b1, 0, 0, 0, -1, 2, 10'b1_01_0_00_00_00);
    applyStimulus("beqNot", 6'h04, 6'h00, 1'b0, 0, 0, 0, -1, 2, 10'b0_01_0_00_00_00);
    applyStimulus("bneZero", 6'h05, 6'h00, 1'b1, 0, 0, 0, -1, 2, 10'b0_01_0_00_00_00);
    applyStimulus("bneTaken", 6'h05, 6'h00, 1'b0, 0, 0, 0, -1, 2, 10'b1_01_0_00_00_00);
    applyStimulus("j", 6'h02, 6'h00, 1'b0, 0, 0, 0, -1, 2, 10'b1_10_0_00_00_00);
    applyStimulus("jal", 6'h03, 6'h00, 1'b0, 0, 0, 0, -1, 2, 10'b1_10_1_10_10_00);
    applyStimulus("jr", 6'h00, 6'h08, 1'b0, 0, 0, 0, -1, 2, 10'b1_11_0_00_00_00);

    $display("[TB] illegal instructions");
    applyStimulus("badOp", 6'h3f, 6'h00, 1'b0, 0, 0, 4, -1, 2, 10'b0_00_0_00_00_01);
    pulseReset("badOp");
    applyStimulus("badFunct", 6'h00, 6'h07, 1'b0, 0, 0, 4, -1, 2, 10'b0_00_0_00_00_01);
    pulseReset("badFunct");

    $display("[TB] fetch timeout");
    applyStimulus("timeout", 6'h23, 6'h00, 1'b0, 4, 0, 3, -1, 4, 10'b0_00_0_00_00_10);
    pulseReset("timeout");
    applyStimulus("readyAtLimit", 6'h08, 6'h00, 1'b0, 3, 0, 0, -1, 3, 10'b1_00_0_00_00_00);

    $display("[TB] reset during store");
    applyStimulus("swReset", 6'h2b, 6'h00, 1'b0, 0, 2, 0, 4, -1, 10'd0);
    checkEn       = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    checkOutput("swMidMemwrite", 22'(bus.memwrite), 22'd1);
    reset = 1'b0;
    #1;
    checkOutput("resetDropsMemwrite", 22'(bus.memwrite), 22'd0);
    checkOutput("resetAllZero", dutOut, 22'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus("jAfterReset", 6'h02, 6'h00, 1'b0, 0, 0, 0, -1, 2, 10'b1_10_0_00_00_00);

    checkEn = 1'b0;
    #20;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
